// File: rtl/instruction_loader.sv
// Program download sequencer: clears instruction memory, forwards received bytes as
// one-cycle write strobes, assembles MSB-first words and ends on HALT, overflow or timeout.
module instruction_loader #(
  parameter int                 NB_DATA        = 32,
  parameter int                 NB_BYTE        = 8,
  parameter int                 N_INSTRUCTIONS = 64,
  parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hFFFF_FFFF,
  parameter int                 TIMEOUT_CYCLES = 1000000,
  parameter int                 NB_COUNT       = $clog2(N_INSTRUCTIONS + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  output logic [NB_BYTE-1:0]  o_imem_write_data,
  output logic                o_imem_write_enable,
  output logic                o_imem_reset,
  output logic                o_loading,
  output logic                o_done,
  output logic                o_error,
  output logic [1:0]          o_error_code,
  output logic [NB_COUNT-1:0] o_word_count
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_INDEX       = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int NB_TIMER       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [NB_INDEX-1:0] LAST_INDEX    = NB_INDEX'(BYTES_PER_WORD - 1);
  localparam logic [NB_COUNT-1:0] MAX_WORDS     = NB_COUNT'(N_INSTRUCTIONS);
  localparam logic [NB_TIMER-1:0] TIMEOUT_LIMIT = NB_TIMER'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RECEIVE, S_DONE, S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_OVERFLOW = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_e;

  state_e              state_q, state_d;
  err_e                err_q, err_d;
  logic [NB_INDEX-1:0] index_q, index_d;
  logic [NB_DATA-1:0]  word_q, word_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic [NB_TIMER-1:0] timer_q, timer_d;
  logic [NB_BYTE-1:0]  wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic                rx_ready_q, imem_reset_q, loading_q, done_q, error_q;
  logic                handshake;

  // Ready is a registered copy of "in RECEIVE", so it also gates the handshake.
  assign handshake = i_rx_valid & rx_ready_q;

  always_comb begin
    // NOTE: every next-state value gets its default first, so no path can infer a latch.
    state_d = state_q;
    err_d   = err_q;
    index_d = index_q;
    word_d  = word_q;
    count_d = count_q;
    timer_d = timer_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;

    case (state_q)
      S_CLEAR: state_d = S_RECEIVE;

      S_RECEIVE: begin
        if (handshake) begin
          wen_d   = 1'b1;
          wdata_d = i_rx_data;
          word_d  = {word_q[NB_DATA-NB_BYTE-1:0], i_rx_data};
          timer_d = '0;
          if (index_q == LAST_INDEX) begin
            index_d = '0;
            count_d = count_q + NB_COUNT'(1);
            // HALT wins over overflow when the final slot holds the HALT word.
            if (word_d == HALT_WORD) begin
              state_d = S_DONE;
            end else if (count_d == MAX_WORDS) begin
              state_d = S_ERROR;
              err_d   = ERR_OVERFLOW;
            end
          end else begin
            index_d = index_q + NB_INDEX'(1);
          end
        end else if (index_q != '0) begin
          timer_d = timer_q + NB_TIMER'(1);
          if (timer_d == TIMEOUT_LIMIT) begin
            state_d = S_ERROR;
            err_d   = ERR_TIMEOUT;
          end
        end
      end

      default: begin
        // IDLE, DONE and ERROR all (re)start a load; bookkeeping is wiped on entry to CLEAR.
        if (i_start) begin
          state_d = S_CLEAR;
          err_d   = ERR_NONE;
          index_d = '0;
          word_d  = '0;
          count_d = '0;
          timer_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q      <= S_IDLE;
      err_q        <= ERR_NONE;
      index_q      <= '0;
      word_q       <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      rx_ready_q   <= 1'b0;
      imem_reset_q <= 1'b0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      index_q      <= index_d;
      word_q       <= word_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      rx_ready_q   <= (state_d == S_RECEIVE);
      imem_reset_q <= (state_d == S_CLEAR);
      loading_q    <= (state_d == S_CLEAR) || (state_d == S_RECEIVE);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERROR);
    end
  end

  assign o_rx_ready          = rx_ready_q;
  assign o_imem_write_data   = wdata_q;
  assign o_imem_write_enable = wen_q;
  assign o_imem_reset        = imem_reset_q;
  assign o_loading           = loading_q;
  assign o_done              = done_q;
  assign o_error             = error_q;
  assign o_error_code        = err_q;
  assign o_word_count        = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed load scenarios with random bytes, checked every
// cycle against a queue-based model of the download rules.
module tb_instruction_loader;

  localparam int N        = 4;
  localparam int T        = 16;
  localparam int NB_COUNT = $clog2(N + 1);

  logic                i_clock = 1'b0;
  logic                i_reset = 1'b0;
  logic                i_start = 1'b0;
  logic [7:0]          i_rx_data = 8'h00;
  logic                i_rx_valid = 1'b0;
  logic                o_rx_ready, o_imem_write_enable, o_imem_reset;
  logic                o_loading, o_done, o_error;
  logic [7:0]          o_imem_write_data;
  logic [1:0]          o_error_code;
  logic [NB_COUNT-1:0] o_word_count;

  instruction_loader #(
    .N_INSTRUCTIONS (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clock             (i_clock),
    .i_reset             (i_reset),
    .i_start             (i_start),
    .i_rx_data           (i_rx_data),
    .i_rx_valid          (i_rx_valid),
    .o_rx_ready          (o_rx_ready),
    .o_imem_write_data   (o_imem_write_data),
    .o_imem_write_enable (o_imem_write_enable),
    .o_imem_reset        (o_imem_reset),
    .o_loading           (o_loading),
    .o_done              (o_done),
    .o_error             (o_error),
    .o_error_code        (o_error_code),
    .o_word_count        (o_word_count)
  );

  always #5 i_clock = ~i_clock;

  typedef enum {PH_IDLE, PH_CLEAR, PH_RECV, PH_DONE, PH_ERR} phase_t;

  int         checks = 0;
  int         failures = 0;
  phase_t     m_ph = PH_IDLE;
  logic [7:0] m_bytes[$];
  int         m_idle = 0;
  int         m_count = 0;
  int         m_code = 0;
  logic       e_wen = 1'b0;
  logic [7:0] e_wdata = 8'h00;
  int         load_strobes = 0;
  int         reset_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model by the download rules, then compare outputs.
  task automatic tick(input logic rst_n, input logic start, input logic valid, input logic [7:0] data);
    logic        hs;
    logic [31:0] w;
    int          n;
    i_reset    = rst_n;
    i_start    = start;
    i_rx_valid = valid;
    i_rx_data  = data;
    hs    = (m_ph == PH_RECV) && valid;
    e_wen = hs;
    if (hs) e_wdata = data;
    if (!rst_n) begin
      m_ph = PH_IDLE; m_count = 0; m_code = 0; m_idle = 0;
      m_bytes.delete();
      e_wen = 1'b0;
    end else begin
      case (m_ph)
        PH_CLEAR: m_ph = PH_RECV;
        PH_RECV: begin
          if (hs) begin
            m_bytes.push_back(data);
            m_idle = 0;
            n = m_bytes.size();
            if (n % 4 == 0) begin
              m_count = n / 4;
              w = {m_bytes[n-4], m_bytes[n-3], m_bytes[n-2], m_bytes[n-1]};
              if (w == 32'hFFFF_FFFF) m_ph = PH_DONE;
              else if (m_count == N) begin m_ph = PH_ERR; m_code = 1; end
            end
          end else if (m_bytes.size() % 4 != 0) begin
            m_idle++;
            if (m_idle == T) begin m_ph = PH_ERR; m_code = 2; end
          end
        end
        default: if (start) begin
          m_ph = PH_CLEAR; m_count = 0; m_code = 0; m_idle = 0;
          m_bytes.delete();
        end
      endcase
    end
    @(posedge i_clock);
    #1;
    if (o_imem_reset === 1'b1) begin load_strobes = 0; reset_pulses++; end
    if (o_imem_write_enable === 1'b1) load_strobes++;
    check("rx_ready",   32'(o_rx_ready),          32'(m_ph == PH_RECV));
    check("loading",    32'(o_loading),           32'(m_ph == PH_CLEAR || m_ph == PH_RECV));
    check("imem_reset", 32'(o_imem_reset),        32'(m_ph == PH_CLEAR));
    check("done",       32'(o_done),              32'(m_ph == PH_DONE));
    check("error",      32'(o_error),             32'(m_ph == PH_ERR));
    check("error_code", 32'(o_error_code),        32'(m_code));
    check("word_count", 32'(o_word_count),        32'(m_count));
    check("write_en",   32'(o_imem_write_enable), 32'(e_wen));
    if (e_wen) check("write_data", 32'(o_imem_write_data), 32'(e_wdata));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic start_load();
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    idle(1);
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, 1'b0, 1'b1, b);
  endtask

  task automatic send_plain_word();
    send(8'($urandom_range(0, 254)));
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
  endtask

  task automatic send_halt();
    for (int i = 0; i < 4; i++) send(8'hFF);
  endtask

  initial begin
    int pulses_before;
    int strobes_before;
    logic [7:0] prog[8];
    prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Reset state
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b1, 8'hFF);
    check("reset_word_count", 32'(o_word_count), 32'd0);

    // Normal load, back-to-back bytes
    pulses_before = reset_pulses;
    start_load();
    for (int i = 0; i < 8; i++) send(prog[i]);
    idle(2);
    check("normal_reset_pulses", 32'(reset_pulses - pulses_before), 32'd1);
    check("normal_strobes", 32'(load_strobes), 32'd8);
    check("normal_count", 32'(o_word_count), 32'd2);
    check("normal_done", 32'(o_done), 32'd1);
    check("normal_ready_low", 32'(o_rx_ready), 32'd0);

    // Overflow: 16 non-HALT bytes, then a 17th byte that must be refused
    start_load();
    for (int w = 0; w < N; w++) send_plain_word();
    for (int i = 0; i < 3; i++) send(8'h11);
    check("ovf_strobes", 32'(load_strobes), 32'd16);
    check("ovf_error", 32'(o_error), 32'd1);
    check("ovf_code", 32'(o_error_code), 32'd1);
    check("ovf_count", 32'(o_word_count), 32'(N));

    // HALT as the last word that fits: done wins over overflow
    start_load();
    for (int w = 0; w < N - 1; w++) send_plain_word();
    send_halt();
    idle(1);
    check("halt_last_done", 32'(o_done), 32'd1);
    check("halt_last_error", 32'(o_error), 32'd0);
    check("halt_last_count", 32'(o_word_count), 32'(N));

    // Timeout: two bytes then silence; error lands exactly T cycles after the 2nd handshake
    start_load();
    send(8'h12);
    send(8'h34);
    idle(T - 1);
    check("timeout_not_yet", 32'(o_error), 32'd0);
    idle(1);
    check("timeout_error", 32'(o_error), 32'd1);
    check("timeout_code", 32'(o_error_code), 32'd2);
    check("timeout_count", 32'(o_word_count), 32'd0);

    // Reload: a word boundary idle never times out
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    check("reload_imem_reset", 32'(o_imem_reset), 32'd1);
    check("reload_count", 32'(o_word_count), 32'd0);
    check("reload_error_clr", 32'(o_error), 32'd0);
    idle(1);
    send_plain_word();
    idle(100);
    check("no_timeout_idle", 32'(o_error), 32'd0);
    check("no_timeout_ready", 32'(o_rx_ready), 32'd1);
    send_halt();
    idle(1);
    check("reload_done", 32'(o_done), 32'd2 - 32'd1);

    // Gapped valid, including a valid pulse during CLEAR
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    check("gap_done_clr", 32'(o_done), 32'd0);
    tick(1'b1, 1'b0, 1'b1, 8'hA5);
    for (int w = 0; w < N; w++) begin
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(0, 5));
        if (w == N - 1) send(8'hFF);
        else if (b == 0) send(8'($urandom_range(0, 254)));
        else send(8'($urandom_range(0, 255)));
      end
    end
    idle(2);
    check("gap_strobes", 32'(load_strobes), 32'd16);
    check("gap_done", 32'(o_done), 32'd1);

    // Reset mid-word abandons the load
    start_load();
    send(8'h5A);
    send(8'hC3);
    tick(1'b0, 1'b0, 1'b1, 8'h77);
    check("midreset_loading", 32'(o_loading), 32'd0);
    check("midreset_ready", 32'(o_rx_ready), 32'd0);
    strobes_before = load_strobes;
    for (int i = 0; i < 5; i++) send(8'h77);
    check("midreset_no_strobes", 32'(load_strobes), 32'(strobes_before));
    check("midreset_no_error", 32'(o_error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Sequences program download into the byte-wide instruction memory. Bytes arrive from the debug/UART receiver over a valid/ready handshake. The block clears the memory, then forwards each byte as a one-cycle write strobe, since the memory write pointer auto-increments. It assembles bytes MSB-first into 32-bit words, stops on the HALT word, and flags overflow or a stalled mid-word transfer.

Parameters:
NB_DATA, 32, instruction width
NB_BYTE, 8, byte width
N_INSTRUCTIONS, 64, memory capacity in words
HALT_WORD, 32'hFFFF_FFFF, end-of-program marker, written to memory then load ends
TIMEOUT_CYCLES, 1000000, max idle cycles between bytes of one word
NB_COUNT, $clog2(N_INSTRUCTIONS+1), word counter width

Ports:
i_clock  input  1  system clock
i_reset  input  1  synchronous, active-low reset
i_start  input  1  one-cycle pulse: begin a load
i_rx_data  input  NB_BYTE  received byte
i_rx_valid  input  1  i_rx_data valid
o_rx_ready  output  1  byte accepted when i_rx_valid & o_rx_ready
o_imem_write_data  output  NB_BYTE  byte to instruction memory
o_imem_write_enable  output  1  memory write strobe, one cycle per byte
o_imem_reset  output  1  active-high clear pulse to memory (clears data and write pointer)
o_loading  output  1  high in CLEAR/RECEIVE
o_done  output  1  program loaded (HALT seen)
o_error  output  1  load aborted
o_error_code  output  2  01 overflow, 10 timeout, 00 none
o_word_count  output  NB_COUNT  complete words written, including HALT

Behaviour:
- Reset (i_reset=0 at posedge): state IDLE; all outputs 0; byte index, word count, assembly register and timeout counter cleared. Reset mid-load abandons the load. The memory is not cleared by this reset.
- All outputs are registered.
- States: IDLE, CLEAR, RECEIVE, DONE, ERROR.
- IDLE: o_rx_ready=0. i_start moves to CLEAR.
- CLEAR: lasts exactly one cycle with o_imem_reset=1. Clears byte index, word count, error code and o_done. Next state is RECEIVE.
- RECEIVE:
  - o_rx_ready=1.
  - On a handshake in cycle N:
    - o_imem_write_data = byte and o_imem_write_enable=1 in cycle N+1, for exactly one cycle.
    - The byte is shifted into the assembly register, first byte in bits [31:24].
    - Byte index increments modulo 4.
  - Back-to-back handshakes every cycle are legal and produce consecutive write strobes.
  - On the 4th byte of a word, o_word_count increments (visible N+1).
  - If the assembled word equals HALT_WORD, go to DONE.
  - Otherwise, if the new count equals N_INSTRUCTIONS, go to ERROR with code 01.
  - HALT takes priority when both apply (a HALT written as word N_INSTRUCTIONS gives DONE).
  - Timeout counter:
    - Runs only while byte index != 0 and no handshake occurs.
    - Cleared on every handshake.
    - Reaching TIMEOUT_CYCLES goes to ERROR with code 10.
    - A partial word remains in memory.
  - i_start is ignored in RECEIVE.
- DONE: o_done=1, o_rx_ready=0. Incoming bytes are not accepted and no writes occur. i_start goes to CLEAR (reload).
- ERROR: o_error=1, code held, o_rx_ready=0. i_start goes to CLEAR.
- o_rx_ready drops in the cycle after the terminating handshake, so at most the final byte is written. A byte presented in that last accepting cycle is the terminating one; nothing after it is written.
- Never more than 4*N_INSTRUCTIONS write strobes per load. This prevents the memory write pointer from wrapping.

Test Plan:
- Normal load (N_INSTRUCTIONS=4): i_start, then bytes 20,01,00,05 and FF,FF,FF,FF back-to-back -> one o_imem_reset pulse; 8 write strobes carrying the same bytes in order, each 1 cycle after its handshake; o_word_count=2; o_done=1; o_rx_ready=0 afterwards.
- Overflow (N_INSTRUCTIONS=4): 16 non-HALT bytes -> 16 strobes; ERROR, code 01, count=4; a 17th byte is not accepted and produces no strobe. Repeat with the 4th word = HALT -> o_done=1, o_error=0.
- Timeout (TIMEOUT_CYCLES=16): send 2 bytes, then idle -> ERROR, code 10, exactly 16 idle cycles after the 2nd handshake; word count=0. Idle with byte index 0 for 100 cycles -> no timeout.
- Gapped valid: bytes with random 0-5 cycle gaps and a valid pulse in CLEAR -> no acceptance during CLEAR; strobe order and count match the accepted bytes exactly.
- Reload/reset: after DONE, i_start -> o_imem_reset pulse, count=0, o_done=0, new load works. Assert i_reset=0 mid-word -> next cycle IDLE, all outputs 0, no further strobes.
